// File: rtl/reg_select_sequencer_pkg.sv
// Shared types and constants for the register select-and-encode sequencer.
package reg_select_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

endpackage

// File: rtl/reg_select_sequencer_if.sv
// Control-unit / IR side bundle of the register select sequencer.
interface reg_select_sequencer_if #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int DATA_W   = 32,
    parameter int C_W      = 19
);
    logic                gra;
    logic                grb;
    logic                grc;
    logic [IDX_W-1:0]    ra;
    logic [IDX_W-1:0]    rb;
    logic [IDX_W-1:0]    rc;
    logic                rin;
    logic                rout;
    logic                baout;
    logic [C_W-1:0]      c_field;
    logic                start;
    logic [NUM_REGS-1:0] mask;
    logic                dir;
    logic                step;

    logic [NUM_REGS-1:0] r_in;
    logic [NUM_REGS-1:0] r_out;
    logic                ba_zero;
    logic [DATA_W-1:0]   c_sign_extended;
    logic                busy;
    logic                done;
    logic [IDX_W-1:0]    cur_idx;

    modport master (
        output gra, grb, grc, ra, rb, rc, rin, rout, baout, c_field,
               start, mask, dir, step,
        input  r_in, r_out, ba_zero, c_sign_extended, busy, done, cur_idx
    );

    modport slave (
        input  gra, grb, grc, ra, rb, rc, rin, rout, baout, c_field,
               start, mask, dir, step,
        output r_in, r_out, ba_zero, c_sign_extended, busy, done, cur_idx
    );
endinterface

// File: rtl/reg_onehot_decoder.sv
// Register index to one-hot enable decoder; indices beyond NUM_REGS-1 decode to zero.
module reg_onehot_decoder #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic [IDX_W-1:0]    idx,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
            assign onehot[gi] = en && (idx == IDX_W'(gi));
        end
    endgenerate
endmodule

// File: rtl/reg_select_sequencer.sv
// Single-mode Ra/Rb/Rc decode plus block-mode walk over a register mask,
// one register enable per datapath step.
module reg_select_sequencer
    import reg_select_sequencer_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int DATA_W   = 32,
    parameter int C_W      = 19
) (
    input logic                  clk,
    input logic                  reset,
    reg_select_sequencer_if.slave bus
);
    state_t              state_reg;
    logic [NUM_REGS-1:0] pend_reg;
    logic [NUM_REGS-1:0] pend_next;
    logic                dir_reg;
    logic [IDX_W-1:0]    cur_idx_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [IDX_W-1:0]    low_idx;

    logic [IDX_W-1:0]    sel;
    logic                idle;
    logic [NUM_REGS-1:0] single_onehot;
    logic [NUM_REGS-1:0] block_onehot;

    assign sel  = ({IDX_W{bus.gra}} & bus.ra) |
                  ({IDX_W{bus.grb}} & bus.rb) |
                  ({IDX_W{bus.grc}} & bus.rc);
    assign idle = (state_reg == IDLE);

    reg_onehot_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_single_dec (
        .idx    (sel),
        .en     (1'b1),
        .onehot (single_onehot)
    );

    // busy_reg gates the block decoder, so its output is zero outside XFER
    reg_onehot_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_block_dec (
        .idx    (cur_idx_reg),
        .en     (busy_reg),
        .onehot (block_onehot)
    );

    // Pending set after this edge and its lowest member, so the next enable is ready with no bubble
    always_comb begin
        pend_next = pend_reg;
        case (state_reg)
            IDLE:    if (bus.start) pend_next = bus.mask;
            XFER:    if (bus.step)  pend_next = pend_reg & ~block_onehot;
            default: pend_next = pend_reg;
        endcase
        low_idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (pend_next[i]) low_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            pend_reg    <= '0;
            dir_reg     <= DIR_READ;
            cur_idx_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        pend_reg <= pend_next;
                        dir_reg  <= bus.dir;
                        if (pend_next != '0) begin
                            state_reg   <= XFER;
                            busy_reg    <= 1'b1;
                            cur_idx_reg <= low_idx;
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (bus.step) begin
                        pend_reg <= pend_next;
                        if (pend_next == '0) begin
                            state_reg   <= DONE;
                            busy_reg    <= 1'b0;
                            done_reg    <= 1'b1;
                            cur_idx_reg <= '0;
                        end else begin
                            cur_idx_reg <= low_idx;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg   <= IDLE;
                    busy_reg    <= 1'b0;
                    done_reg    <= 1'b0;
                    cur_idx_reg <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.r_in  = '0;
        bus.r_out = '0;
        if (idle) begin
            if (bus.rin)               bus.r_in  = single_onehot;
            if (bus.rout || bus.baout) bus.r_out = single_onehot;
        end else if (dir_reg == DIR_WRITE) begin
            bus.r_in  = block_onehot;
        end else begin
            bus.r_out = block_onehot;
        end
    end

    assign bus.ba_zero         = idle && bus.baout && (sel == '0);
    assign bus.c_sign_extended = {{(DATA_W - C_W){bus.c_field[C_W-1]}}, bus.c_field};
    assign bus.busy            = busy_reg;
    assign bus.done            = done_reg;
    assign bus.cur_idx         = cur_idx_reg;

endmodule

// File: tb/tb_reg_select_sequencer.sv
// Directed scoreboard bench for reg_select_sequencer: single-mode decode, sign
// extension, block walks, handshake stalls, ignored inputs and async reset.
module tb_reg_select_sequencer;
    import reg_select_sequencer_pkg::*;

    localparam int NR = 16;
    localparam int IW = 4;
    localparam int DW = 32;
    localparam int CW = 19;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    reg_select_sequencer_if #(.NUM_REGS(NR), .IDX_W(IW), .DATA_W(DW), .C_W(CW)) bus ();

    reg_select_sequencer #(.NUM_REGS(NR), .IDX_W(IW), .DATA_W(DW), .C_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NR-1:0] r_in;
        logic [NR-1:0] r_out;
        logic          busy;
        logic          done;
        logic          ba_zero;
        logic [IW-1:0] cur;
    } vec_t;

    vec_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic vec_t mk(logic [NR-1:0] ri, logic [NR-1:0] ro,
                                logic b, logic d, logic z, logic [IW-1:0] c);
        vec_t v;
        v.r_in = ri; v.r_out = ro; v.busy = b; v.done = d; v.ba_zero = z; v.cur = c;
        return v;
    endfunction

    task automatic push(vec_t v);
        sb.push_back(v);
    endtask

    // Expected walk for a block transfer with step held high, followed by done and idle
    task automatic push_block(logic [NR-1:0] m, logic d);
        logic [NR-1:0] bit_v;
        for (int i = 0; i < NR; i++) begin
            if (m[i]) begin
                bit_v = '0;
                bit_v[i] = 1'b1;
                push(mk(d ? bit_v : '0, d ? '0 : bit_v, 1'b1, 1'b0, 1'b0, IW'(i)));
            end
        end
        push(mk('0, '0, 1'b0, 1'b1, 1'b0, '0));
        push(mk('0, '0, 1'b0, 1'b0, 1'b0, '0));
    endtask

    task automatic check(string tag);
        vec_t o, e;
        o = mk(bus.r_in, bus.r_out, bus.busy, bus.done, bus.ba_zero, bus.cur_idx);
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s: no expected entry queued, observed %h", tag, o);
            return;
        end
        e = sb.pop_front();
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed r_in=%h r_out=%h busy=%b done=%b ba_zero=%b cur=%0d, expected r_in=%h r_out=%h busy=%b done=%b ba_zero=%b cur=%0d",
                   tag, o.r_in, o.r_out, o.busy, o.done, o.ba_zero, o.cur,
                   e.r_in, e.r_out, e.busy, e.done, e.ba_zero, e.cur);
        end
    endtask

    task automatic check_sx(string tag, logic [DW-1:0] exp);
        vectors++;
        assert (bus.c_sign_extended === exp) else begin
            miscompares++;
            $error("FAIL %s: observed c_sign_extended=%h, expected %h", tag, bus.c_sign_extended, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run(int n, string tag);
        for (int k = 0; k < n; k++) begin
            tick();
            check(tag);
        end
    endtask

    task automatic clear_single();
        bus.gra = 0; bus.grb = 0; bus.grc = 0;
        bus.ra = '0; bus.rb = '0; bus.rc = '0;
        bus.rin = 0; bus.rout = 0; bus.baout = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_single();
        bus.c_field = '0;
        bus.start   = 0;
        bus.mask    = '0;
        bus.dir     = DIR_READ;
        bus.step    = 0;

        // Reset state
        #1;
        push(mk('0, '0, 1'b0, 1'b0, 1'b0, '0));
        check("reset_state");
        tick();
        reset = 1'b0;

        // Single mode
        tick();
        bus.gra = 1; bus.ra = 4'd12; bus.rout = 1;
        #1;
        push(mk('0, 16'h1000, 1'b0, 1'b0, 1'b0, '0));
        check("single_ra_rout");

        tick();
        clear_single();
        bus.grc = 1; bus.rc = 4'd15; bus.rin = 1;
        #1;
        push(mk(16'h8000, '0, 1'b0, 1'b0, 1'b0, '0));
        check("single_rc_rin");

        tick();
        clear_single();
        bus.gra = 1; bus.ra = 4'd0; bus.baout = 1;
        #1;
        push(mk('0, 16'h0001, 1'b0, 1'b0, 1'b1, '0));
        check("single_baout_r0");

        tick();
        clear_single();
        bus.gra = 1; bus.grb = 1; bus.ra = 4'd3; bus.rb = 4'd4; bus.rin = 1;
        #1;
        push(mk(16'h0080, '0, 1'b0, 1'b0, 1'b0, '0));
        check("single_or_fields");

        tick();
        clear_single();
        bus.grb = 1; bus.rb = 4'd5; bus.baout = 1;
        #1;
        push(mk('0, 16'h0020, 1'b0, 1'b0, 1'b0, '0));
        check("single_baout_nonzero");
        clear_single();

        // Sign extension
        bus.c_field = 19'h40000; #1; check_sx("sx_neg", 32'hFFFC0000);
        bus.c_field = 19'h00005; #1; check_sx("sx_pos", 32'h00000005);
        bus.c_field = 19'h3FFFF; #1; check_sx("sx_ones", 32'h0003FFFF);
        bus.c_field = 19'h7FFFF; #1; check_sx("sx_all", 32'hFFFFFFFF);

        // Block read with step held high
        tick();
        bus.mask = 16'h8421; bus.dir = DIR_READ; bus.step = 1; bus.start = 1;
        push_block(16'h8421, DIR_READ);
        run(6, "blk_read");
        bus.step = 0;

        // Handshake stall on a write block
        tick();
        bus.mask = 16'h0006; bus.dir = DIR_WRITE; bus.start = 1;
        for (int k = 0; k < 3; k++) push(mk(16'h0002, '0, 1'b1, 1'b0, 1'b0, 4'd1));
        run(3, "blk_stall_hold");
        bus.step = 1;
        push(mk(16'h0004, '0, 1'b1, 1'b0, 1'b0, 4'd2));
        push(mk('0, '0, 1'b0, 1'b1, 1'b0, '0));
        push(mk('0, '0, 1'b0, 1'b0, 1'b0, '0));
        run(3, "blk_stall_advance");
        bus.step = 0;

        // Empty mask
        tick();
        bus.mask = '0; bus.dir = DIR_READ; bus.start = 1;
        push_block('0, DIR_READ);
        run(2, "blk_empty");

        // start and single-mode strobes during XFER are ignored
        tick();
        bus.mask = 16'h0030; bus.dir = DIR_READ; bus.start = 1;
        push(mk('0, 16'h0010, 1'b1, 1'b0, 1'b0, 4'd4));
        run(1, "xfer_first");
        bus.start = 1; bus.mask = 16'h0001; bus.dir = DIR_WRITE;
        bus.gra = 1; bus.ra = 4'd0; bus.rout = 1; bus.rin = 1; bus.baout = 1;
        #1;
        push(mk('0, 16'h0010, 1'b1, 1'b0, 1'b0, 4'd4));
        check("xfer_ignore_inputs");
        push(mk('0, 16'h0010, 1'b1, 1'b0, 1'b0, 4'd4));
        run(1, "xfer_ignore_start");
        clear_single();
        bus.step = 1;
        push(mk('0, 16'h0020, 1'b1, 1'b0, 1'b0, 4'd5));
        push(mk('0, '0, 1'b0, 1'b1, 1'b0, '0));
        push(mk('0, '0, 1'b0, 1'b0, 1'b0, '0));
        run(3, "xfer_finish");

        // Reset mid-transfer
        tick();
        bus.mask = 16'hFFFF; bus.dir = DIR_WRITE; bus.step = 1; bus.start = 1;
        push(mk(16'h0001, '0, 1'b1, 1'b0, 1'b0, 4'd0));
        push(mk(16'h0002, '0, 1'b1, 1'b0, 1'b0, 4'd1));
        push(mk(16'h0004, '0, 1'b1, 1'b0, 1'b0, 4'd2));
        push(mk(16'h0008, '0, 1'b1, 1'b0, 1'b0, 4'd3));
        run(4, "rst_walk");
        #2;
        reset = 1'b1;
        #1;
        push(mk('0, '0, 1'b0, 1'b0, 1'b0, '0));
        check("rst_async_drop");
        push(mk('0, '0, 1'b0, 1'b0, 1'b0, '0));
        run(1, "rst_held");
        reset = 1'b0;
        push(mk('0, '0, 1'b0, 1'b0, 1'b0, '0));
        run(1, "rst_no_done");

        // New transfer after reset starts from the new mask's lowest bit
        bus.mask = 16'h0050; bus.dir = DIR_READ; bus.start = 1;
        push_block(16'h0050, DIR_READ);
        run(4, "post_rst_walk");
        bus.step = 0;

        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_select_sequencer.md
# reg_select_sequencer

Parametrised successor to the register select-and-encode logic. Single mode: decodes the Ra/Rb/Rc instruction fields into one-hot register in/out enables and sign-extends the constant field, combinationally, as the control unit expects. Block mode: given a register mask, an FSM walks the set bits in ascending order and asserts one register enable at a time under a datapath step handshake, for load/store-multiple and push/pop sequences. Sits between the control unit/IR and the register file.

## Interface
- NUM_REGS, 16: number of general registers (2..64).
- IDX_W, $clog2(NUM_REGS): register index field width.
- DATA_W, 32: bus width.
- C_W, 19: constant field width in the IR.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears FSM and all registered outputs.
- gra, grb, grc  in  1 each  field gate strobes from control unit.
- ra, rb, rc  in  IDX_W each  register fields from IR.
- rin, rout, baout  in  1 each  single-mode write / read / base-address-read strobes.
- c_field  in  C_W  constant field from IR.
- start  in  1  block-mode start pulse.
- mask  in  NUM_REGS  block-mode register set, sampled on start.
- dir  in  1  block direction, sampled on start: 0 = read registers (r_out), 1 = write registers (r_in).
- step  in  1  datapath has consumed/produced the current register word.
- r_in  out  NUM_REGS  one-hot (or zero) register write enables.
- r_out  out  NUM_REGS  one-hot (or zero) register read enables.
- ba_zero  out  1  high when baout selects register 0 (register 0 must drive zero).
- c_sign_extended  out  DATA_W  c_field sign-extended from bit C_W-1.
- busy  out  1  block transfer in progress.
- done  out  1  one-cycle pulse at block completion.
- cur_idx  out  IDX_W  index of register currently enabled in block mode (0 when idle).

## Operation
- Single mode (state IDLE): sel = ({IDX_W{gra}}&ra) | ({IDX_W{grb}}&rb) | ({IDX_W{grc}}&rc); r_in = rin ? onehot(sel) : 0; r_out = (rout|baout) ? onehot(sel) : 0; ba_zero = baout & (sel==0). sel >= NUM_REGS yields all-zero enables.
- c_sign_extended = {{(DATA_W-C_W){c_field[C_W-1]}}, c_field}, combinational in all states.
- FSM states: IDLE, XFER, DONE.
- IDLE: start captures mask into pend and dir into dir_q; pend nonzero -> XFER, pend zero -> DONE.
- XFER: cur_idx = lowest set bit of pend; enable dir_q ? r_in : r_out at that bit, others zero; single-mode strobes ignored. On step, clear that bit; if remaining pend zero -> DONE, else stay in XFER with next lowest bit.
- DONE: done=1, busy=0, enables zero; unconditionally -> IDLE next cycle. start in DONE ignored.
- start while busy ignored; mask/dir changes while busy ignored.
- ba_zero is 0 outside IDLE.

## Timing
- Reset values: FSM=IDLE, pend=0, busy=0, done=0, cur_idx=0, block enables 0; single-mode outputs follow inputs combinationally.
- Single mode: zero-cycle latency, purely combinational from inputs.
- start at edge T -> busy and first enable valid in cycle T+1.
- Enable held until step sampled high; step at edge E -> next register's enable in cycle E+1 (no bubble), or done in E+1 after the last register.
- step in IDLE/DONE ignored. step held high continuously: one register per cycle.
- N set bits, step always high: busy for N cycles, done in cycle N+1 after start.
- Empty mask: done in cycle T+1, busy never asserted.
- Reset mid-transfer: immediate return to IDLE, all block enables and done drop asynchronously, no done pulse.

## Structure
- Shared package: state enum (IDLE, XFER, DONE), DIR_READ/DIR_WRITE constants.
- One sub-module: reg_onehot_decoder (IDX_W index + enable -> NUM_REGS one-hot, zero for out-of-range), instantiated for single mode and block mode; lowest-set-bit priority encoder kept inline.

## Test plan
- Single mode: gra=1, ra=12, rout=1 -> r_out=16'h1000, r_in=0; grc=1, rc=15, rin=1 -> r_in=16'h8000; baout=1, ra=0, gra=1 -> r_out=16'h0001, ba_zero=1.
- Sign extension: c_field=19'h40000 -> c_sign_extended=32'hFFFC0000; c_field=19'h00005 -> 32'h00000005.
- Block read: mask=16'h8421, dir=0, step held 1 -> r_out 0x0001,0x0020,0x0400,0x8000 in cycles T+1..T+4, done at T+5, busy T+1..T+4.
- Handshake stall: mask=16'h0006, dir=1, step low 3 cycles then pulsed -> r_in=0x0002 held until step, then 0x0004 next cycle, then done.
- Edges: mask=0 -> done at T+1, busy never high; start during XFER ignored; gra/rout during XFER do not disturb enables.
- Reset during XFER with mask=16'hFFFF after 3 steps -> all outputs zero immediately, no done; new start afterwards begins from lowest bit of new mask.
